reg_wb_arbiter: RTL and testbench

// - Shares the register file's single write port (rd_addr/rd_in/write; writable regs 8..11) between two requesters:

---
 rtl/rf_pkg.sv | 21 ++
 rtl/wb_hold_slot.sv | 30 +++
 rtl/reg_wb_arbiter.sv | 95 +++++++++
 tb/tb_reg_wb_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback path: sizes and the
// holding-slot record used by the writeback arbiter.
package rf_pkg;

  localparam int REG_WIDTH = 8;
  localparam int WR_REGS   = 4;
  localparam int ADDR_W    = $clog2(WR_REGS);
  localparam int WR_BASE   = 8;

  typedef struct packed {
    logic                 valid;
    logic [ADDR_W-1:0]    addr;
    logic [REG_WIDTH-1:0] data;
  } wb_slot_t;

  // Only relevant when WR_REGS is not a power of two.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return int'(a) < WR_REGS;
  endfunction

endpackage

// File: rtl/wb_hold_slot.sv
// One-deep holding register for a writeback requester. Accepts when empty
// or when being drained this cycle, so a steady stream retires at 1/cycle.
module wb_hold_slot
  import rf_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [REG_WIDTH-1:0] data,
  input  logic                 clear,
  output logic                 ready,
  output wb_slot_t             slot
);

  assign ready = !reset && (!slot.valid || clear);

  // NOTE: only the valid flag is reset; addr/data are don't-care while
  // valid=0, so leaving them unreset keeps the datapath flops plain.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot.valid <= 1'b0;
    end else if (valid && ready) begin
      slot <= '{valid: 1'b1, addr: addr, data: data};
    end else if (clear) begin
      slot.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Arbitrates the register file's single write port between the ALU (port 0)
// and load (port 1) writebacks; same-register writes retire in order.
module reg_wb_arbiter
  import rf_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [ADDR_W-1:0]    req_addr0,
  input  logic [ADDR_W-1:0]    req_addr1,
  input  logic [REG_WIDTH-1:0] req_data0,
  input  logic [REG_WIDTH-1:0] req_data1,
  output logic                 write,
  output logic [ADDR_W-1:0]    rd_addr,
  output logic [REG_WIDTH-1:0] rd_in,
  output logic [WR_REGS-1:0]   pending,
  output logic                 grant_id
);

  wb_slot_t             slot0, slot1, gslot;
  logic                 gnt, any_full, both_full, same_addr;
  logic [1:0]           clr, acc;
  logic                 age_q;   // index of the older slot
  logic                 rr_q;
  logic [ADDR_W-1:0]    last_addr_q;
  logic [REG_WIDTH-1:0] last_data_q;

  wb_hold_slot u_slot0 (
    .clk(clk), .reset(reset), .valid(req_valid[0]), .addr(req_addr0),
    .data(req_data0), .clear(clr[0]), .ready(req_ready[0]), .slot(slot0)
  );

  wb_hold_slot u_slot1 (
    .clk(clk), .reset(reset), .valid(req_valid[1]), .addr(req_addr1),
    .data(req_data1), .clear(clr[1]), .ready(req_ready[1]), .slot(slot1)
  );

  assign any_full  = slot0.valid || slot1.valid;
  assign both_full = slot0.valid && slot1.valid;
  assign same_addr = slot0.addr == slot1.addr;
  assign acc       = req_valid & req_ready;

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch; blocking '=' is used here only.
  always_comb begin
    gnt = 1'b0;
    if (both_full)        gnt = same_addr ? age_q : rr_q;
    else if (slot1.valid) gnt = 1'b1;
    gslot = gnt ? slot1 : slot0;
    clr   = 2'b00;
    if (any_full && !reset) clr = gnt ? 2'b10 : 2'b01;
    write    = any_full && !reset && addr_ok(gslot.addr);
    rd_addr  = write ? gslot.addr : last_addr_q;
    rd_in    = write ? gslot.data : last_data_q;
    grant_id = gnt;
  end

  always_comb begin
    pending = '0;
    for (int r = 0; r < WR_REGS; r++) begin
      pending[r] = (slot0.valid && slot0.addr == ADDR_W'(r)) ||
                   (slot1.valid && slot1.addr == ADDR_W'(r));
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      age_q       <= 1'b0;
      rr_q        <= 1'b0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      if (write) begin
        last_addr_q <= gslot.addr;
        last_data_q <= gslot.data;
      end
      if (both_full && !same_addr) rr_q <= ~gnt;
      // A lone refill makes that slot the younger one; a tie favours slot 0.
      case (acc)
        2'b11:   age_q <= 1'b0;
        2'b01:   age_q <= 1'b1;
        2'b10:   age_q <= 1'b0;
        default: age_q <= age_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && any_full) assert (addr_ok(gslot.addr));
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: reset, single port, contention,
// same-register ordering, round-robin fairness, drain-and-refill.
module tb_reg_wb_arbiter;
  import rf_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0]           req_valid, req_ready;
  logic [ADDR_W-1:0]    req_addr0, req_addr1, rd_addr;
  logic [REG_WIDTH-1:0] req_data0, req_data1, rd_in;
  logic                 write, grant_id;
  logic [WR_REGS-1:0]   pending;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  logic [REG_WIDTH-1:0] rf [WR_REGS];

  always #5 clk = ~clk;

  reg_wb_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_data0(req_data0), .req_data1(req_data1),
    .write(write), .rd_addr(rd_addr), .rd_in(rd_in),
    .pending(pending), .grant_id(grant_id)
  );

  // Register file model fed by the write port, used for end-value checks.
  always @(negedge clk) begin
    if (write === 1'b1) begin
      wr_count++;
      rf[rd_addr] = rd_in;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [ADDR_W-1:0] a0, input logic [7:0] d0,
                       input logic [ADDR_W-1:0] a1, input logic [7:0] d1);
    req_valid = v;
    req_addr0 = a0;
    req_data0 = d0;
    req_addr1 = a1;
    req_data1 = d1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_d [8];
    int         i0, i1, nw, snap;
    logic       acc0, acc1;

    for (int r = 0; r < WR_REGS; r++) rf[r] = '0;
    reset = 1'b1;
    drive(2'b00, 0, 0, 0, 0);
    @(negedge clk);
    check("ready_in_reset", req_ready, 2'b00);
    check("write_in_reset", write, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", req_ready, 2'b11);
    check("rst_write", write, 1'b0);
    check("rst_pending", pending, 4'b0000);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_rd_in", rd_in, 0);
    check("rst_grant_id", grant_id, 0);

    // Single port write of A5 to register 2.
    tick();
    drive(2'b01, 2, 8'hA5, 0, 0);
    tick();
    drive(2'b00, 0, 0, 0, 0);
    @(negedge clk);
    check("single_write", write, 1'b1);
    check("single_addr", rd_addr, 2);
    check("single_data", rd_in, 8'hA5);
    check("single_gid", grant_id, 0);
    check("single_pending", pending, 4'b0100);
    tick();
    @(negedge clk);
    check("single_idle_write", write, 1'b0);
    check("single_idle_pending", pending, 4'b0000);
    check("single_hold_addr", rd_addr, 2);
    check("single_hold_data", rd_in, 8'hA5);

    // Contention on different registers: rr_ptr=0 so port 0 goes first.
    tick();
    drive(2'b11, 1, 8'h11, 3, 8'h22);
    tick();
    drive(2'b00, 0, 0, 0, 0);
    @(negedge clk);
    check("cont1_gid", grant_id, 0);
    check("cont1_data", rd_in, 8'h11);
    check("cont1_ready", req_ready, 2'b01);
    check("cont1_pending", pending, 4'b1010);
    tick();
    @(negedge clk);
    check("cont2_write", write, 1'b1);
    check("cont2_gid", grant_id, 1);
    check("cont2_addr", rd_addr, 3);
    check("cont2_data", rd_in, 8'h22);
    tick();
    @(negedge clk);
    check("cont_idle", write, 1'b0);

    // Same register: port 1 first, port 0 one cycle later.
    tick();
    drive(2'b10, 0, 0, 0, 8'h33);
    tick();
    drive(2'b01, 0, 8'h44, 0, 0);
    @(negedge clk);
    check("same1_gid", grant_id, 1);
    check("same1_data", rd_in, 8'h33);
    tick();
    drive(2'b00, 0, 0, 0, 0);
    @(negedge clk);
    check("same2_gid", grant_id, 0);
    check("same2_data", rd_in, 8'h44);
    tick();
    @(negedge clk);
    check("same_idle", write, 1'b0);
    tick();
    check("same_final_reg0", rf[0], 8'h44);

    // Simultaneous same register with rr_ptr=1: age (slot 0 older) wins.
    drive(2'b11, 0, 8'h55, 0, 8'h66);
    tick();
    drive(2'b00, 0, 0, 0, 0);
    @(negedge clk);
    check("age1_gid", grant_id, 0);
    check("age1_data", rd_in, 8'h55);
    check("age1_pending", pending, 4'b0001);
    tick();
    @(negedge clk);
    check("age2_gid", grant_id, 1);
    check("age2_data", rd_in, 8'h66);
    tick();
    tick();
    check("age_final_reg0", rf[0], 8'h66);

    // Reset with both slots full: held writes are discarded.
    drive(2'b11, 1, 8'h77, 2, 8'h88);
    tick();
    drive(2'b00, 0, 0, 0, 0);
    reset = 1'b1;
    snap = wr_count;
    @(negedge clk);
    check("midrst_write", write, 1'b0);
    check("midrst_ready", req_ready, 2'b00);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("postrst_write", write, 1'b0);
    check("postrst_pending", pending, 4'b0000);
    check("postrst_ready", req_ready, 2'b11);
    check("postrst_rd_in", rd_in, 0);
    tick();
    @(negedge clk);
    check("postrst_no_write", wr_count, snap);

    // Round-robin fairness: 4 writes per port, distinct registers.
    exp_d = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
    i0 = 0;
    i1 = 0;
    nw = 0;
    tick();
    for (int c = 0; c < 20 && nw < 8; c++) begin
      req_valid = {i1 < 4, i0 < 4};
      req_addr0 = ADDR_W'(i0 % 2);
      req_data0 = 8'h10 + 8'(i0);
      req_addr1 = ADDR_W'(2 + i1 % 2);
      req_data1 = 8'h20 + 8'(i1);
      @(negedge clk);
      if (write) begin
        check($sformatf("rr_gid_%0d", nw), grant_id, nw % 2);
        check($sformatf("rr_data_%0d", nw), rd_in, exp_d[nw]);
        nw++;
      end
      acc0 = req_valid[0] && req_ready[0];
      acc1 = req_valid[1] && req_ready[1];
      tick();
      if (acc0) i0++;
      if (acc1) i1++;
    end
    drive(2'b00, 0, 0, 0, 0);
    check("rr_write_count", nw, 8);
    @(negedge clk);
    check("rr_drained", write, 1'b0);

    // Drain-and-refill on port 0 at one write per cycle.
    tick();
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) drive(2'b01, 3, 8'(k), 0, 0);
      else        drive(2'b00, 0, 0, 0, 0);
      if (k > 1) begin
        @(negedge clk);
        check($sformatf("dr_write_%0d", k - 1), write, 1'b1);
        check($sformatf("dr_data_%0d", k - 1), rd_in, k - 1);
        check($sformatf("dr_ready_%0d", k - 1), req_ready[0], 1'b1);
      end
      tick();
    end
    @(negedge clk);
    check("dr_idle", write, 1'b0);
    tick();
    check("dr_final_reg3", rf[3], 8'h04);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
